// File: rtl/binarize_thresh_ctrl_if.sv
// binarize_thresh_ctrl_if: pixel stream and priority-encoder bus of the threshold controller
interface binarize_thresh_ctrl_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0]      pix_in;
  logic                  pix_in_valid;
  logic                  pix_in_ready;
  logic                  pix_out_bit;
  logic                  pix_out_valid;
  logic                  pix_out_ready;
  logic [2**PIX_W-1:0]   enc_in;
  logic                  enc_enable;
  logic [PIX_W-1:0]      enc_out;
  logic                  enc_valid;
  modport slave (
    input  pix_in, pix_in_valid, pix_out_ready, enc_out, enc_valid,
    output pix_in_ready, pix_out_bit, pix_out_valid, enc_in, enc_enable
  );
  modport master (
    output pix_in, pix_in_valid, pix_out_ready, enc_out, enc_valid,
    input  pix_in_ready, pix_out_bit, pix_out_valid, enc_in, enc_enable
  );
endinterface

// File: rtl/binarize_thresh_ctrl.sv
// binarize_thresh_ctrl: binarizes a pixel stream and retunes the threshold to (min+max)/2 each frame
module binarize_thresh_ctrl #(
  parameter int PIX_W       = 8,
  parameter int FRAME_PIX   = 4096,
  parameter int INIT_THRESH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  binarize_thresh_ctrl_if.slave bus,
  output logic [PIX_W-1:0]      thresh,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err
);
  localparam int N  = 2**PIX_W;
  localparam int CW = FRAME_PIX > 1 ? $clog2(FRAME_PIX) : 1;
  typedef enum logic [2:0] {IDLE, ACCUM, ENC_MIN, WAIT_MIN, ENC_MAX, WAIT_MAX, UPDATE} state_t;
  state_t           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d, mask_rev;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PIX_W-1:0] thresh_q, thresh_d, min_q, min_d, max_q, max_d;
  logic             out_valid_q, out_valid_d, out_bit_q, out_bit_d;
  logic             enc_en_q, enc_en_d, bad_q, bad_d, err_q, err_d;
  logic             accept;
  logic [PIX_W:0]   sum;
  assign bus.pix_in_ready  = state_q == ACCUM && (!out_valid_q || bus.pix_out_ready);
  assign accept            = bus.pix_in_valid && bus.pix_in_ready;
  assign sum               = {1'b0, min_q} + {1'b0, max_q};
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign mask_rev[i] = mask_q[N-1-i];
  end
  assign bus.enc_in        = state_q == ENC_MAX ? mask_rev : mask_q;
  assign bus.enc_enable    = enc_en_q;
  assign bus.pix_out_valid = out_valid_q;
  assign bus.pix_out_bit   = out_bit_q;
  assign thresh            = thresh_q;
  assign frame_done        = state_q == UPDATE;
  assign busy              = state_q != IDLE;
  assign err               = err_q;
  // next-state: frame accumulation, two encoder passes, threshold update
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    thresh_d    = thresh_q;
    min_d       = min_q;
    max_d       = max_q;
    bad_d       = bad_q;
    err_d       = err_q;
    out_valid_d = accept | (out_valid_q & ~bus.pix_out_ready);
    out_bit_d   = accept ? bus.pix_in >= thresh_q : out_bit_q;
    unique case (state_q)
      IDLE: if (frame_start) begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: if (frame_start) begin
        mask_d = '0;
        cnt_d  = '0;
      end else if (accept) begin
        mask_d[bus.pix_in] = 1'b1;
        cnt_d              = cnt_q + 1'b1;
        state_d            = cnt_q == CW'(FRAME_PIX - 1) ? ENC_MIN : ACCUM;
      end
      ENC_MIN: state_d = WAIT_MIN;
      WAIT_MIN: begin
        min_d   = bus.enc_out;
        bad_d   = !bus.enc_valid;
        err_d   = err_q | !bus.enc_valid;
        state_d = ENC_MAX;
      end
      ENC_MAX: state_d = WAIT_MAX;
      WAIT_MAX: begin
        max_d   = ~bus.enc_out;
        bad_d   = bad_q | !bus.enc_valid;
        err_d   = err_q | !bus.enc_valid;
        state_d = UPDATE;
      end
      UPDATE: begin
        thresh_d = bad_q ? thresh_q : PIX_W'(sum >> 1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    enc_en_d = state_d == ENC_MIN || state_d == ENC_MAX;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      thresh_q    <= PIX_W'(INIT_THRESH);
      min_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      enc_en_q    <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      thresh_q    <= thresh_d;
      min_q       <= min_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      enc_en_q    <= enc_en_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_binarize_thresh_ctrl.sv
// tb_binarize_thresh_ctrl: directed frames with a bit scoreboard and a behavioural encoder
module tb_binarize_thresh_ctrl;
  localparam int FP = 16;
  logic       clk = 1'b0, rst = 1'b1, frame_start = 1'b0, force_inv = 1'b0;
  logic [7:0] thresh;
  logic       frame_done, busy, err;
  int         checks = 0, errors = 0;
  int         exp_thresh = 128, fmin, fmax;
  logic       exp_err = 1'b0, sb_e;
  logic [255:0] exp_mask;
  logic       exp_q[$];
  binarize_thresh_ctrl_if #(.PIX_W(8)) bus();
  binarize_thresh_ctrl #(.PIX_W(8), .FRAME_PIX(FP), .INIT_THRESH(128)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bus(bus),
    .thresh(thresh), .frame_done(frame_done), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] lowest(input logic [255:0] v);
    logic [7:0] r = 8'd0;
    for (int i = 255; i >= 0; i--) if (v[i]) r = 8'(i);
    return r;
  endfunction
  // registered lowest-set-bit encoder, output held on zero input
  always @(posedge clk) begin
    if (rst) begin
      bus.enc_out   <= 8'd0;
      bus.enc_valid <= 1'b0;
    end else if (bus.enc_enable) begin
      if (bus.enc_in != '0 && !force_inv) begin
        bus.enc_out   <= lowest(bus.enc_in);
        bus.enc_valid <= 1'b1;
      end else bus.enc_valid <= 1'b0;
    end
  end
  // output side of the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.pix_out_valid && bus.pix_out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra: observed output bit %0b, expected no output", bus.pix_out_bit);
      end
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        checks++;
        assert (bus.pix_out_bit === sb_e) else begin
          errors++;
          $error("FAIL pix_out_bit: observed %0b expected %0b", bus.pix_out_bit, sb_e);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fmin = 256;
    fmax = -1;
    exp_mask = '0;
  endtask
  task automatic send(input int p);
    int n = 0;
    bus.pix_in = 8'(p);
    bus.pix_in_valid = 1'b1;
    @(negedge clk);
    while (!bus.pix_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", bus.pix_in_ready, 1'b1);
    if (bus.pix_in_ready) begin
      exp_q.push_back(p >= exp_thresh);
      exp_mask[p] = 1'b1;
      if (p < fmin) fmin = p;
      if (p > fmax) fmax = p;
    end
    tick();
    bus.pix_in_valid = 1'b0;
  endtask
  task automatic not_early();
    @(negedge clk);
    chk("not_early_enable", bus.enc_enable, 1'b0);
    chk("not_early_ready", bus.pix_in_ready, 1'b1);
    tick();
  endtask
  task automatic finish_frame(input logic inv);
    logic [255:0] rev;
    int nt;
    for (int i = 0; i < 256; i++) rev[i] = exp_mask[255-i];
    nt = inv ? exp_thresh : (fmin + fmax) / 2;
    if (inv) exp_err = 1'b1;
    force_inv = inv;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) force_inv = 1'b0;
      chk("enc_enable", bus.enc_enable, k == 1 || k == 3);
      chk("frame_done", frame_done, k == 5);
      if (k == 1) chk("enc_in_min", bus.enc_in, exp_mask);
      if (k == 3) chk("enc_in_max", bus.enc_in, rev);
      if (k == 5) chk("thresh_before", thresh, exp_thresh);
      if (k == 6) begin
        chk("thresh_after", thresh, nt);
        chk("busy_idle", busy, 1'b0);
        chk("err", err, exp_err);
      end
    end
    exp_thresh = nt;
    tick();
  endtask
  initial begin
    bus.pix_in = 8'd0;
    bus.pix_in_valid = 1'b0;
    bus.pix_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_thresh", thresh, 128);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", bus.pix_in_ready, 1'b0);
    chk("rst_out_valid", bus.pix_out_valid, 1'b0);
    chk("rst_out_bit", bus.pix_out_bit, 1'b0);
    chk("rst_enc_enable", bus.enc_enable, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_enc_in", bus.enc_in, '0);
    rst = 1'b0;
    tick();
    bus.pix_in_valid = 1'b1;
    tick();
    chk("idle_no_ready", bus.pix_in_ready, 1'b0);
    chk("idle_no_output", bus.pix_out_valid, 1'b0);
    bus.pix_in_valid = 1'b0;
    start_frame();
    chk("accum_busy", busy, 1'b1);
    chk("accum_ready", bus.pix_in_ready, 1'b1);
    for (int i = 0; i < FP; i++) send(100);
    finish_frame(1'b0);
    start_frame();
    send(10);
    send(250);
    for (int i = 0; i < FP - 2; i++) send(10);
    finish_frame(1'b0);
    start_frame();
    send(129);
    send(130);
    send(255);
    for (int i = 0; i < FP - 3; i++) send(0);
    finish_frame(1'b0);
    start_frame();
    for (int i = 0; i < FP; i++) send(i < FP / 2 ? 0 : 1);
    finish_frame(1'b0);
    start_frame();
    for (int i = 0; i < 5; i++) send(77);
    start_frame();
    chk("abort_mask", bus.enc_in, '0);
    chk("abort_busy", busy, 1'b1);
    bus.pix_out_ready = 1'b0;
    send(200);
    bus.pix_in = 8'd201;
    bus.pix_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", bus.pix_in_ready, 1'b0);
      chk("bp_out_valid", bus.pix_out_valid, 1'b1);
    end
    bus.pix_in_valid = 1'b0;
    bus.pix_out_ready = 1'b1;
    send(201);
    for (int i = 0; i < FP - 3; i++) send(3 * i + 5);
    not_early();
    send(99);
    finish_frame(1'b1);
    start_frame();
    for (int i = 0; i < 7; i++) send(50);
    rst = 1'b1;
    #2;
    chk("mid_rst_thresh", thresh, 128);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_out_valid", bus.pix_out_valid, 1'b0);
    chk("mid_rst_enc_in", bus.enc_in, '0);
    chk("mid_rst_in_ready", bus.pix_in_ready, 1'b0);
    exp_q.delete();
    exp_thresh = 128;
    exp_err = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_frame();
    for (int i = 0; i < FP - 1; i++) send(100);
    not_early();
    send(100);
    finish_frame(1'b0);
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
